// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   // Modulus of each BCD digit position.
   localparam int unsigned MIN_TENS_LIM = 10;
   localparam int unsigned MIN_ONES_LIM = 10;
   localparam int unsigned SEC_TENS_LIM = 6;
   localparam int unsigned SEC_ONES_LIM = 10;

   // Clamp one BCD digit to lim-1 when it is out of range.
   function automatic logic [3:0] sat_digit(input logic [3:0] d, input int unsigned lim);
      if ({28'd0, d} >= lim) begin
         return 4'(lim - 1);
      end
      return d;
   endfunction

   // Clamp every digit of a packed MM:SS value.
   function automatic logic [15:0] sat_bcd(input logic [15:0] v);
      return {sat_digit(v[15:12], MIN_TENS_LIM),
              sat_digit(v[11:8],  MIN_ONES_LIM),
              sat_digit(v[7:4],   SEC_TENS_LIM),
              sat_digit(v[3:0],   SEC_ONES_LIM)};
   endfunction

endpackage

// File: rtl/lim_dec.sv
// One modulo-L digit decrementer with borrow in/out. Inputs above L-1 are
// treated as L-1 so a corrupted digit can never produce an out-of-range result.
module lim_dec #(
   parameter int unsigned L = 10
) (
   input  logic [$clog2(L)-1:0] a,
   input  logic                 bi,
   output logic [$clog2(L)-1:0] diff,
   output logic                 bo
);

   localparam int unsigned W = $clog2(L);
   localparam logic [W-1:0] MAX = W'(L - 1);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] a_sat;

   // Saturate the input, then subtract the incoming borrow with wrap to L-1.
   always_comb begin
      a_sat = (a > MAX) ? MAX : a;
      diff  = a_sat;
      bo    = 1'b0;
      if (bi) begin
         if (a_sat == '0) begin
            diff = MAX;
            bo   = 1'b1;
         end else begin
            diff = a_sat - ONE;
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with a one-second prescaler.
// Control inputs are plain levels sampled on every rising edge; when several
// are high together the priority is clear > load > start > pause > tick.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        load,
   input  logic        clear,
   input  logic [15:0] load_value,
   output logic [15:0] count,
   output logic        running,
   output logic        expired,
   output logic        done,
   output state_t      dbg_state
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   state_t        state_q, state_d;
   logic [15:0]   count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;

   logic          tick;
   logic [3:0]    sec_ones_d;
   logic [2:0]    sec_tens_d;
   logic [3:0]    min_ones_d;
   logic [3:0]    min_tens_d;
   logic          b_so, b_st, b_mo, b_mt;
   logic [15:0]   dec_value;
   logic [15:0]   load_sat;

   assign tick     = (state_q == ST_RUN) && (presc_q == P_LAST);
   assign load_sat = sat_bcd(load_value);

   lim_dec #(.L(SEC_ONES_LIM)) u_sec_ones (
      .a(count_q[3:0]), .bi(tick), .diff(sec_ones_d), .bo(b_so)
   );
   lim_dec #(.L(SEC_TENS_LIM)) u_sec_tens (
      .a(count_q[6:4]), .bi(b_so), .diff(sec_tens_d), .bo(b_st)
   );
   lim_dec #(.L(MIN_ONES_LIM)) u_min_ones (
      .a(count_q[11:8]), .bi(b_st), .diff(min_ones_d), .bo(b_mo)
   );
   lim_dec #(.L(MIN_TENS_LIM)) u_min_tens (
      .a(count_q[15:12]), .bi(b_mo), .diff(min_tens_d), .bo(b_mt)
   );

   // A borrow out of the top digit would mean wrapping below 00:00; hold instead.
   assign dec_value = b_mt ? count_q : {min_tens_d, min_ones_d, 1'b0, sec_tens_d, sec_ones_d};

   // Next-state, next-count and prescaler decode in priority order.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      done_d  = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         count_d = 16'h0000;
         presc_d = '0;
      end else if (load) begin
         state_d = ST_IDLE;
         count_d = load_sat;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (count_q != 16'h0000)) begin
                  state_d = ST_RUN;
                  presc_d = '0;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (tick) begin
                  presc_d = '0;
                  count_d = dec_value;
                  if (dec_value == 16'h0000) begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + P_ONE;
               end
            end
            ST_PAUSED: begin
               if (start) begin
                  state_d = ST_RUN;
               end
            end
            ST_EXPIRED: begin
               count_d = 16'h0000;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= 16'h0000;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

   assign count     = count_q;
   assign running   = (state_q == ST_RUN);
   assign expired   = (state_q == ST_EXPIRED);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance at TICK_DIV=2 and one at TICK_DIV=4.
module tb_countdown_timer;
   import countdown_pkg::*;

   localparam bit DA = 1'b0;
   localparam bit DB = 1'b1;

   logic clk;

   logic        a_reset, a_start, a_pause, a_load, a_clear;
   logic [15:0] a_lv, a_count;
   logic        a_running, a_expired, a_done;
   state_t      a_state;

   logic        b_reset, b_start, b_pause, b_load, b_clear;
   logic [15:0] b_lv, b_count;
   logic        b_running, b_expired, b_done;
   state_t      b_state;

   int cyc = 0;
   int checks = 0;
   int fails = 0;
   int a_done_n = 0;
   int b_done_n = 0;

   // {count, running, expired, done, state}
   logic [20:0] exp_q[$];
   int          exp_cyc_q[$];
   bit          exp_dut_q[$];
   string       exp_name_q[$];

   countdown_timer #(.TICK_DIV(2)) u_dut_a (
      .clk(clk), .reset(a_reset), .start(a_start), .pause(a_pause),
      .load(a_load), .clear(a_clear), .load_value(a_lv), .count(a_count),
      .running(a_running), .expired(a_expired), .done(a_done), .dbg_state(a_state)
   );

   countdown_timer #(.TICK_DIV(4)) u_dut_b (
      .clk(clk), .reset(b_reset), .start(b_start), .pause(b_pause),
      .load(b_load), .clear(b_clear), .load_value(b_lv), .count(b_count),
      .running(b_running), .expired(b_expired), .done(b_done), .dbg_state(b_state)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic rst_n, clr, ld, st, ps, input logic [15:0] lv);
      a_reset = rst_n; a_clear = clr; a_load = ld; a_start = st; a_pause = ps; a_lv = lv;
   endtask

   task automatic set_b(input logic rst_n, clr, ld, st, ps, input logic [15:0] lv);
      b_reset = rst_n; b_clear = clr; b_load = ld; b_start = st; b_pause = ps; b_lv = lv;
   endtask

   // Queue the expected outputs d edges from now.
   task automatic exp_at(input int d, input bit dut, input string name,
                         input logic [15:0] cnt, input state_t st, input logic dn);
      exp_q.push_back({cnt, st == ST_RUN, st == ST_EXPIRED, dn, st});
      exp_cyc_q.push_back(cyc + d);
      exp_dut_q.push_back(dut);
      exp_name_q.push_back(name);
   endtask

   // Monitor: compare every due expectation on the falling edge.
   logic [20:0] m_exp, m_act;
   int          m_cyc;
   bit          m_dut;
   string       m_name;
   always @(negedge clk) begin
      if (a_done === 1'b1) a_done_n++;
      if (b_done === 1'b1) b_done_n++;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
         m_exp  = exp_q.pop_front();
         m_cyc  = exp_cyc_q.pop_front();
         m_dut  = exp_dut_q.pop_front();
         m_name = exp_name_q.pop_front();
         m_act  = m_dut ? {b_count, b_running, b_expired, b_done, b_state}
                        : {a_count, a_running, a_expired, a_done, a_state};
         checks++;
         if (m_cyc != cyc || m_act !== m_exp) begin
            fails++;
            $display("FAIL %s (dut %0d, cycle %0d due %0d): got count=%h run=%b exp=%b done=%b st=%0d, expected count=%h run=%b exp=%b done=%b st=%0d",
                     m_name, m_dut, cyc, m_cyc,
                     m_act[20:5], m_act[4], m_act[3], m_act[2], m_act[1:0],
                     m_exp[20:5], m_exp[4], m_exp[3], m_exp[2], m_exp[1:0]);
         end
      end
   end

   initial begin
      // Reset held low while load and start are also asserted.
      set_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0042);
      set_b(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0042);
      exp_at(1, DA, "reset_a", 16'h0000, ST_IDLE, 1'b0);
      exp_at(1, DB, "reset_b", 16'h0000, ST_IDLE, 1'b0);
      step(1);
      step(1);
      set_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      set_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      step(1);

      // ---------------- DUT A, TICK_DIV=2 ----------------
      // Load saturation of out-of-range digits.
      set_a(1, 0, 1, 0, 0, 16'hFFFF); exp_at(1, DA, "load_sat_ffff", 16'h9959, ST_IDLE, 0); step(1);
      set_a(1, 0, 1, 0, 0, 16'hA5F3); exp_at(1, DA, "load_sat_a5f3", 16'h9553, ST_IDLE, 0); step(1);
      set_a(1, 0, 1, 0, 0, 16'h3C8B); exp_at(1, DA, "load_sat_3c8b", 16'h3959, ST_IDLE, 0); step(1);
      set_a(1, 0, 1, 0, 0, 16'h0000); exp_at(1, DA, "load_zero", 16'h0000, ST_IDLE, 0); step(1);

      // Start with zero count stays idle.
      set_a(1, 0, 0, 1, 0, 16'h0000);
      exp_at(1, DA, "start_zero_1", 16'h0000, ST_IDLE, 0);
      exp_at(2, DA, "start_zero_2", 16'h0000, ST_IDLE, 0);
      step(2);

      // Count 00:03 down to expiry.
      set_a(1, 0, 1, 0, 0, 16'h0003); exp_at(1, DA, "load_0003", 16'h0003, ST_IDLE, 0); step(1);
      set_a(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DA, "run_enter", 16'h0003, ST_RUN, 0); step(1);
      set_a(1, 0, 0, 0, 0, 16'h0000);
      exp_at(1, DA, "pre_tick1",    16'h0003, ST_RUN, 0);
      exp_at(2, DA, "tick1",        16'h0002, ST_RUN, 0);
      exp_at(3, DA, "pre_tick2",    16'h0002, ST_RUN, 0);
      exp_at(4, DA, "tick2",        16'h0001, ST_RUN, 0);
      exp_at(5, DA, "pre_tick3",    16'h0001, ST_RUN, 0);
      exp_at(6, DA, "expire_done",  16'h0000, ST_EXPIRED, 1);
      exp_at(7, DA, "expired_hold", 16'h0000, ST_EXPIRED, 0);
      step(7);

      // Start and pause ignored in EXPIRED; load leaves it.
      set_a(1, 0, 0, 1, 1, 16'h0000);
      exp_at(1, DA, "expired_ignore_1", 16'h0000, ST_EXPIRED, 0);
      exp_at(2, DA, "expired_ignore_2", 16'h0000, ST_EXPIRED, 0);
      step(2);
      set_a(1, 0, 1, 0, 0, 16'h1000); exp_at(1, DA, "expired_load", 16'h1000, ST_IDLE, 0); step(1);

      // Full borrow chain 10:00 -> 09:59.
      set_a(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DA, "run_1000", 16'h1000, ST_RUN, 0); step(1);
      set_a(1, 0, 0, 0, 0, 16'h0000);
      exp_at(1, DA, "pre_borrow",   16'h1000, ST_RUN, 0);
      exp_at(2, DA, "borrow_chain", 16'h0959, ST_RUN, 0);
      step(2);
      set_a(1, 1, 0, 0, 0, 16'h0000); exp_at(1, DA, "clear_run", 16'h0000, ST_IDLE, 0); step(1);

      // Clear beats a simultaneous load.
      set_a(1, 0, 1, 0, 0, 16'h0005); exp_at(1, DA, "load_0005", 16'h0005, ST_IDLE, 0); step(1);
      set_a(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DA, "run_0005", 16'h0005, ST_RUN, 0); step(1);
      set_a(1, 0, 0, 0, 0, 16'h0000); exp_at(1, DA, "run_0005_p1", 16'h0005, ST_RUN, 0); step(1);
      set_a(1, 1, 1, 0, 0, 16'h0030); exp_at(1, DA, "clear_over_load", 16'h0000, ST_IDLE, 0); step(1);
      set_a(1, 0, 0, 0, 0, 16'h0000); exp_at(1, DA, "after_clear", 16'h0000, ST_IDLE, 0); step(1);

      // Reset mid-run beats load and start, no done pulse.
      set_a(1, 0, 1, 0, 0, 16'h0002); exp_at(1, DA, "load_0002", 16'h0002, ST_IDLE, 0); step(1);
      set_a(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DA, "run_0002", 16'h0002, ST_RUN, 0); step(1);
      set_a(1, 0, 0, 0, 0, 16'h0000); exp_at(1, DA, "run_0002_p1", 16'h0002, ST_RUN, 0); step(1);
      set_a(0, 0, 1, 1, 0, 16'h0077); exp_at(1, DA, "reset_mid_run", 16'h0000, ST_IDLE, 0); step(1);
      set_a(1, 0, 0, 0, 0, 16'h0000);
      for (int i = 1; i <= 4; i++) exp_at(i, DA, "post_reset", 16'h0000, ST_IDLE, 0);
      step(4);

      // ---------------- DUT B, TICK_DIV=4 ----------------
      // Pause after two RUN cycles, hold five cycles, resume.
      set_b(1, 0, 1, 0, 0, 16'h0010); exp_at(1, DB, "b_load_0010", 16'h0010, ST_IDLE, 0); step(1);
      set_b(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DB, "b_run_enter", 16'h0010, ST_RUN, 0); step(1);
      set_b(1, 0, 0, 0, 0, 16'h0000);
      exp_at(1, DB, "b_run_p1", 16'h0010, ST_RUN, 0);
      exp_at(2, DB, "b_run_p2", 16'h0010, ST_RUN, 0);
      step(2);
      set_b(1, 0, 0, 0, 1, 16'h0000); exp_at(1, DB, "b_pause_enter", 16'h0010, ST_PAUSED, 0); step(1);
      for (int i = 1; i <= 4; i++) exp_at(i, DB, "b_paused_hold", 16'h0010, ST_PAUSED, 0);
      step(4);
      set_b(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DB, "b_resume", 16'h0010, ST_RUN, 0); step(1);
      set_b(1, 0, 0, 0, 0, 16'h0000);
      exp_at(1, DB, "b_resume_p3",   16'h0010, ST_RUN, 0);
      exp_at(2, DB, "b_resume_tick", 16'h0009, ST_RUN, 0);
      step(2);

      // Load from PAUSED and from RUN returns to IDLE.
      set_b(1, 0, 0, 0, 1, 16'h0000); exp_at(1, DB, "b_pause2", 16'h0009, ST_PAUSED, 0); step(1);
      set_b(1, 0, 1, 0, 0, 16'h0123); exp_at(1, DB, "b_load_paused", 16'h0123, ST_IDLE, 0); step(1);
      set_b(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DB, "b_run_0123", 16'h0123, ST_RUN, 0); step(1);
      set_b(1, 0, 1, 0, 0, 16'h0456); exp_at(1, DB, "b_load_run", 16'h0456, ST_IDLE, 0); step(1);

      // First decrement exactly four edges after entering RUN; start held.
      set_b(1, 0, 0, 1, 0, 16'h0000); exp_at(1, DB, "b_run_0456", 16'h0456, ST_RUN, 0); step(1);
      for (int i = 1; i <= 3; i++) exp_at(i, DB, "b_pre_tick", 16'h0456, ST_RUN, 0);
      exp_at(4, DB, "b_first_tick", 16'h0455, ST_RUN, 0);
      step(4);
      set_b(1, 0, 0, 0, 0, 16'h0000);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_cyc_q.size() > 0; i++) step(1);
      while (exp_cyc_q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL %s: expectation never checked (due cycle %0d)", exp_name_q[0], exp_cyc_q[0]);
         void'(exp_q.pop_front());
         void'(exp_cyc_q.pop_front());
         void'(exp_dut_q.pop_front());
         void'(exp_name_q.pop_front());
      end

      checks++;
      if (a_done_n != 1) begin
         fails++;
         $display("FAIL a_done_pulses: got %0d, expected %0d", a_done_n, 1);
      end
      checks++;
      if (b_done_n != 0) begin
         fails++;
         $display("FAIL b_done_pulses: got %0d, expected %0d", b_done_n, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
